// File: rtl/painterengine_gpu_pkg.sv
// Shared GPU definitions: fetch FSM state encoding, pixel word width and burst sizing helper.
package painterengine_gpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  // Next burst length: whatever is left of the frame, capped at the max burst.
  function automatic logic [7:0] burst_len(input logic [31:0] remaining,
                                           input logic [31:0] max_len);
    return 8'((remaining > max_len) ? max_len : remaining);
  endfunction

endpackage

// File: rtl/painterengine_gpu_dvi_pixel_fetch_if.sv
// Memory read-burst port of the DVI pixel fetcher (request/ack plus unthrottled data beats).
interface painterengine_gpu_dvi_pixel_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import painterengine_gpu_pkg::*;

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [WORD_W-1:0]     rd_data;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_valid, rd_data
  );

endinterface

// File: rtl/painterengine_gpu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is readable whenever not empty.
module painterengine_gpu_sync_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign rdata  = mem[rd_ptr[AW-1:0]];

  // Extra pointer MSB distinguishes full from empty; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/painterengine_gpu_dvi_pixel_fetch.sv
// Frame fetcher for the DVI stage: burst-reads ARGB32 words into a FWFT FIFO popped by next_rgb.
// Optional PAINTERENGINE_GPU_DVI_FETCH_STATS_EN adds underflow count and FIFO low-water outputs.
module painterengine_gpu_dvi_pixel_fetch
  import painterengine_gpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          i_wire_pixel_clock,
  input  logic                          i_wire_resetn,
  input  logic                          i_wire_start,
  input  logic [ADDR_WIDTH-1:0]         i_wire_frame_addr,
  input  logic [15:0]                   i_wire_clip_width,
  input  logic [15:0]                   i_wire_clip_height,
  painterengine_gpu_dvi_pixel_fetch_if.master rd_bus,
  input  logic                          i_wire_next_rgb,
  output logic [WORD_W-1:0]             o_wire_rgba,
  output logic                          o_wire_fetch_done,
  output logic                          o_wire_underflow
`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
  ,
  output logic [31:0]                   o_wire_underflow_cnt,
  output logic [15:0]                   o_wire_fifo_min
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remaining_req;
  logic [7:0]            beats;
  logic                  rd_req_q;
  logic [7:0]            rd_len_q;

  logic                  start_ok;
  logic [31:0]           total_c;
  logic [31:0]           free_c;
  logic [7:0]            len_c;
  logic                  fifo_push;
  logic                  pop_fire;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [WORD_W-1:0]     fifo_head;

  assign start_ok  = i_wire_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign total_c   = 32'(i_wire_clip_width) * 32'(i_wire_clip_height);
  assign fifo_push = (state == ST_RECV) && rd_bus.rd_valid;
  assign pop_fire  = i_wire_next_rgb && !fifo_empty;
  // Space counts the slot freed by a pop in this same cycle.
  assign free_c    = 32'(FIFO_DEPTH) - 32'(fifo_count) + 32'(pop_fire);
  assign len_c     = burst_len(remaining_req, 32'(BURST_LEN));

  assign rd_bus.rd_req  = rd_req_q;
  assign rd_bus.rd_addr = addr_q;
  assign rd_bus.rd_len  = rd_len_q;
  assign o_wire_rgba    = fifo_empty ? '0 : fifo_head;

  painterengine_gpu_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (i_wire_pixel_clock),
    .rst_n (i_wire_resetn),
    .clr   (start_ok),
    .push  (fifo_push),
    .pop   (i_wire_next_rgb),
    .wdata (rd_bus.rd_data),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Fetch FSM and address generator.
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state             <= ST_IDLE;
      addr_q            <= '0;
      remaining_req     <= '0;
      beats             <= '0;
      rd_req_q          <= 1'b0;
      rd_len_q          <= '0;
      o_wire_fetch_done <= 1'b0;
      o_wire_underflow  <= 1'b0;
    end else begin
      if (i_wire_next_rgb && fifo_empty) o_wire_underflow <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            addr_q           <= i_wire_frame_addr;
            remaining_req    <= total_c;
            rd_req_q         <= 1'b0;
            o_wire_underflow <= 1'b0;
            if (total_c == 32'd0) begin
              state             <= ST_DONE;
              o_wire_fetch_done <= 1'b1;
            end else begin
              state             <= ST_REQ;
              o_wire_fetch_done <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (rd_req_q && rd_bus.rd_ack) begin
            rd_req_q      <= 1'b0;
            addr_q        <= addr_q + ADDR_WIDTH'({rd_len_q, 2'b00});
            remaining_req <= remaining_req - 32'(rd_len_q);
            beats         <= rd_len_q;
            state         <= ST_RECV;
          end else if (!rd_req_q && (free_c >= 32'(len_c))) begin
            rd_req_q <= 1'b1;
            rd_len_q <= len_c;
          end
        end
        ST_RECV: begin
          if (rd_bus.rd_valid) begin
            beats <= beats - 8'd1;
            if (beats == 8'd1) begin
              if (remaining_req != 32'd0) begin
                state <= ST_REQ;
              end else begin
                state             <= ST_DONE;
                o_wire_fetch_done <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
  always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      o_wire_underflow_cnt <= '0;
      o_wire_fifo_min      <= '0;
    end else if (start_ok) begin
      o_wire_underflow_cnt <= '0;
      o_wire_fifo_min      <= 16'hFFFF;
    end else begin
      if (i_wire_next_rgb && fifo_empty && (o_wire_underflow_cnt != 32'hFFFF_FFFF))
        o_wire_underflow_cnt <= o_wire_underflow_cnt + 32'd1;
      if ((state == ST_REQ || state == ST_RECV) && (16'(fifo_count) < o_wire_fifo_min))
        o_wire_fifo_min <= 16'(fifo_count);
    end
  end
`endif

  // Space is reserved before every request, so a push into a full FIFO means broken bookkeeping.
  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_resetn && fifo_push && !pop_fire) assert (!fifo_full);
  end

endmodule

// File: tb/tb_painterengine_gpu_dvi_pixel_fetch.sv
// Directed bench for the DVI pixel fetcher with a burst memory model and pixel scoreboard.
module tb_painterengine_gpu_dvi_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] frame_addr;
  logic [15:0] clip_w;
  logic [15:0] clip_h;
  logic        next_rgb;
  logic [31:0] rgba;
  logic        done;
  logic        underflow;
`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
  logic [31:0] ucnt;
  logic [15:0] fmin;
`endif

  int errors = 0;
  int checks = 0;
  int beat_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] burst_addr_q[$];
  logic [31:0] burst_len_q[$];

  always #5 clk = ~clk;

  painterengine_gpu_dvi_pixel_fetch_if #(.ADDR_WIDTH(32)) bus ();

  painterengine_gpu_dvi_pixel_fetch #(
    .FIFO_DEPTH (128),
    .BURST_LEN  (64),
    .ADDR_WIDTH (32)
  ) dut (
    .i_wire_pixel_clock (clk),
    .i_wire_resetn      (rst_n),
    .i_wire_start       (start),
    .i_wire_frame_addr  (frame_addr),
    .i_wire_clip_width  (clip_w),
    .i_wire_clip_height (clip_h),
    .rd_bus             (bus.master),
    .i_wire_next_rgb    (next_rgb),
    .o_wire_rgba        (rgba),
    .o_wire_fetch_done  (done),
    .o_wire_underflow   (underflow)
`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
    ,
    .o_wire_underflow_cnt (ucnt),
    .o_wire_fifo_min      (fmin)
`endif
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {8'hC3, a[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Memory: ack immediately, then stream len beats back-to-back; abandons the burst on reset.
  initial begin : mem_model
    logic [31:0] b_addr;
    logic [31:0] b_len;
    bus.rd_ack   = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.rd_req === 1'b1) begin
        b_addr = bus.rd_addr;
        b_len  = 32'(bus.rd_len);
        burst_addr_q.push_back(b_addr);
        burst_len_q.push_back(b_len);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        beat_cnt = 0;
        for (int i = 0; i < int'(b_len); i++) begin
          if (rst_n !== 1'b1) break;
          bus.rd_valid = 1'b1;
          bus.rd_data  = pat(b_addr + 32'(4 * i));
          beat_cnt++;
          @(negedge clk);
        end
        bus.rd_valid = 1'b0;
      end
    end
  end

  task automatic start_frame(input logic [31:0] a, input logic [15:0] w, input logic [15:0] h);
    burst_addr_q.delete();
    burst_len_q.delete();
    for (int k = 0; k < int'(w) * int'(h); k++) exp_q.push_back(pat(a + 32'(4 * k)));
    frame_addr = a;
    clip_w     = w;
    clip_h     = h;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int t = 0;
    while (rgba === 32'h0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, rgba, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
    next_rgb = 1'b1;
    @(negedge clk);
    next_rgb = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(done), 32'h1);
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [31:0] a, input logic [31:0] l);
    chk({tag, "_addr"}, (burst_addr_q.size() > idx) ? burst_addr_q[idx] : 32'hFFFF_FFFF, a);
    chk({tag, "_len"},  (burst_len_q.size()  > idx) ? burst_len_q[idx]  : 32'hFFFF_FFFF, l);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    rst_n = 1'b0; start = 1'b0; next_rgb = 1'b0;
    frame_addr = '0; clip_w = '0; clip_h = '0;
    repeat (3) @(negedge clk);
    chk("reset_req",  32'(bus.rd_req), 32'h0);
    chk("reset_rgba", rgba, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_uf",   32'(underflow), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4x2 frame: a single 8-word burst, then in-order pops
    start_frame(32'h1000_0000, 16'd4, 16'd2);
    chk("t1_done_low", 32'(done), 32'h0);
    wait_done("t1_done", 200);
    chk("t1_nbursts", 32'(burst_addr_q.size()), 32'd1);
    chk_burst("t1_b0", 0, 32'h1000_0000, 32'd8);
    for (int i = 0; i < 8; i++) pop_check("t1_pop");
    chk("t1_empty_rgba", rgba, 32'h0);
    chk("t1_no_uf", 32'(underflow), 32'h0);

    // Pop on empty FIFO
    next_rgb = 1'b1;
    @(negedge clk);
    next_rgb = 1'b0;
    chk("t4_uf_set", 32'(underflow), 32'h1);
    chk("t4_rgba_zero", rgba, 32'h0);
`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
    chk("t4_ucnt", ucnt, 32'd1);
`endif

    // 100x2 frame into a 128-deep FIFO with no pops: stalls after two bursts
    start_frame(32'h2000_0000, 16'd100, 16'd2);
    chk("t4_uf_cleared", 32'(underflow), 32'h0);
`ifdef PAINTERENGINE_GPU_DVI_FETCH_STATS_EN
    chk("t4_ucnt_cleared", ucnt, 32'd0);
`endif
    repeat (300) @(negedge clk);
    chk("t3_two_bursts", 32'(burst_addr_q.size()), 32'd2);
    chk("t3_req_stalled", 32'(bus.rd_req), 32'h0);
    chk("t3_done_low", 32'(done), 32'h0);
    for (int i = 0; i < 63; i++) pop_check("t3_pop");
    repeat (10) @(negedge clk);
    chk("t3_stall_63", 32'(burst_addr_q.size()), 32'd2);
    chk("t3_req_63", 32'(bus.rd_req), 32'h0);
    pop_check("t3_pop64");
    t = 0;
    while (burst_addr_q.size() < 3 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("t3_resumed", 32'(burst_addr_q.size()), 32'd3);
    for (int i = 0; i < 136; i++) pop_check("t2_pop");
    wait_done("t2_done", 50);
    chk("t2_nbursts", 32'(burst_addr_q.size()), 32'd4);
    chk_burst("t2_b0", 0, 32'h2000_0000, 32'd64);
    chk_burst("t2_b1", 1, 32'h2000_0100, 32'd64);
    chk_burst("t2_b2", 2, 32'h2000_0200, 32'd64);
    chk_burst("t2_b3", 3, 32'h2000_0300, 32'd8);
    chk("t2_empty", rgba, 32'h0);
    chk("t2_no_uf", 32'(underflow), 32'h0);

    // Zero-size frame: done immediately, no request
    start_frame(32'h4000_0000, 16'd0, 16'd5);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_no_req", 32'(bus.rd_req), 32'h0);
    repeat (5) @(negedge clk);
    chk("t5_no_burst", 32'(burst_addr_q.size()), 32'd0);
    chk("t5_req_idle", 32'(bus.rd_req), 32'h0);

    // Reset in the middle of a 64-beat burst
    start_frame(32'h3000_0000, 16'd64, 16'd2);
    t = 0;
    while (beat_cnt < 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t6_beat10", 32'(beat_cnt >= 10), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(bus.rd_req), 32'h0);
    chk("t6_rgba", rgba, 32'h0);
    chk("t6_done", 32'(done), 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rgba_after", rgba, 32'h0);
    start_frame(32'h3000_0000, 16'd4, 16'd1);
    wait_done("t6_done_new", 200);
    chk("t6_nbursts", 32'(burst_addr_q.size()), 32'd1);
    chk_burst("t6_b0", 0, 32'h3000_0000, 32'd4);
    for (int i = 0; i < 4; i++) pop_check("t6_pop");
    chk("t6_empty", rgba, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
